sap_datapath: RTL and testbench
===============================

SAP_DATAPATH -- requirements
Module: sap_datapath

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the bus, A, B and ALU width.
REQ-002 Parameter PC_W, default 4, SHALL set the program counter width (PC_W < DATA_W).
REQ-003 clk  in  1  single clock; all registers SHALL update on its rising edge.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 bus_in  in  DATA_W  value driven onto the shared bus by external agents.
REQ-006 bus_out  out  DATA_W  internal bus value.
REQ-007 bus_drive  out  1  high when any internal output enable is asserted.
REQ-008 pc_oe, pc_jmp, pc_inc  in  1 each  counter output enable, load, increment.
REQ-009 a_we, a_oe, b_we, b_oe  in  1 each  register A/B write and output enables.
REQ-010 alu_oe, alu_sub, flags_we  in  1 each  ALU result enable, subtract select, flag latch enable.
REQ-011 pc_val (PC_W), a_val (DATA_W), b_val (DATA_W)  out  current register contents.
REQ-012 cf, zf  out  1 each  registered carry and zero flags.
REQ-013 bus_conflict  out  1  more than one internal output enable asserted.

Function
REQ-014 Internal bus SHALL be the highest-priority enabled source (alu_oe > a_oe > b_oe > pc_oe), else bus_in; bus_out SHALL equal it combinationally.
REQ-015 PC on bus SHALL be zero-extended: upper DATA_W-PC_W bits 0.
REQ-016 ALU result SHALL be combinational: A+B when alu_sub=0, A+~B+1 when alu_sub=1, truncated to DATA_W.
REQ-017 Carry SHALL be bit DATA_W of the DATA_W+1-bit sum (subtract: 1 = no borrow).
REQ-018 On clk with flags_we=1, cf and zf SHALL load carry and (result==0); otherwise hold. Flags SHALL update regardless of alu_oe.
REQ-019 a_we/b_we SHALL load the internal bus at the clock edge; one-cycle latency; a_we with alu_oe in the same cycle SHALL load A+B (or A-B) computed from pre-edge values.
REQ-020 Counter: pc_jmp SHALL load internal bus[PC_W-1:0]; else pc_inc SHALL increment modulo 2^PC_W (15 -> 0); else hold. pc_jmp wins over pc_inc.
REQ-021 Register writes sourcing the bus from their own output (e.g. a_oe with a_we) SHALL hold the value.
REQ-022 bus_drive SHALL equal OR of alu_oe, a_oe, b_oe, pc_oe.

Reset
REQ-023 clr=1 SHALL immediately clear pc_val, a_val, b_val, cf, zf to 0, overriding any same-cycle write, jmp or inc.
REQ-024 Combinational outputs (bus_out, bus_drive, bus_conflict) SHALL continue tracking enables during reset.

Configuration
REQ-025 With macro SAP_DP_CONFLICT_DET_EN defined, bus_conflict SHALL be 1 whenever two or more of alu_oe, a_oe, b_oe, pc_oe are high; without it bus_conflict SHALL be tied 0. Priority mux is unchanged in both cases.

Structure
REQ-026 Package sap_dp_pkg SHALL hold DATA_W/PC_W defaults and the bus-source select enum (SRC_EXT, SRC_ALU, SRC_A, SRC_B, SRC_PC).
REQ-027 A and B SHALL be two instances of one sub-module dp_reg (write-enabled register with async clear); counter and ALU SHALL be inline in sap_datapath.

Verification
REQ-028 Assert clr mid-cycle after loading A=0x55, pc=7 -> all registers and flags read 0 immediately.
REQ-029 bus_in=0x38, a_we; bus_in=0x23, b_we; then alu_oe+a_we+flags_we -> a_val=0x5B, cf=0, zf=0, bus_out=0x5B during enable.
REQ-030 A=0x38, B=0x23, alu_sub+alu_oe+flags_we -> bus_out=0x15, cf=1; A=0x23, B=0x38 -> 0xEB, cf=0; A=B=0x23 -> 0x00, zf=1.
REQ-031 A=0xFF, B=0x01, add with flags_we -> result 0x00, cf=1, zf=1; repeat with flags_we=0 -> flags unchanged.
REQ-032 16 pc_inc cycles from 0 -> pc_val wraps to 0; pc_jmp+pc_inc with bus_in=0x0E -> pc_val=0xE; pc_oe -> bus_out=0x0E, bus_drive=1.
REQ-033 a_oe and pc_oe together -> bus_out=A, bus_conflict=1 only with SAP_DP_CONFLICT_DET_EN.

Source files
------------

// File: rtl/sap_dp_pkg.sv
// Shared defaults and the bus-source select for the SAP datapath slice.
package sap_dp_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PC_W_DEF   = 4;

  typedef enum logic [2:0] {
    SRC_EXT,
    SRC_ALU,
    SRC_A,
    SRC_B,
    SRC_PC
  } bus_src_t;

endpackage

// File: rtl/sap_datapath_reg.sv
// dp_reg: write-enabled register with asynchronous active-high clear.
module dp_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      q <= '0;
    else if (we)
      q <= d;
  end

endmodule

// File: rtl/sap_datapath.sv
// SAP datapath: shared bus, A/B registers, adder/subtractor with flags, program counter.
// Optional macro SAP_DP_CONFLICT_DET_EN enables the bus_conflict detector.
module sap_datapath
  import sap_dp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  input  logic              pc_oe,
  input  logic              pc_jmp,
  input  logic              pc_inc,
  input  logic              a_we,
  input  logic              a_oe,
  input  logic              b_we,
  input  logic              b_oe,
  input  logic              alu_oe,
  input  logic              alu_sub,
  input  logic              flags_we,
  output logic [PC_W-1:0]   pc_val,
  output logic [DATA_W-1:0] a_val,
  output logic [DATA_W-1:0] b_val,
  output logic              cf,
  output logic              zf,
  output logic              bus_conflict
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  bus_src_t          src;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] b_opnd;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;

  // Subtraction is A + ~B + 1, so carry out of the top bit means "no borrow".
  assign b_opnd  = alu_sub ? ~b_val : b_val;
  assign sum     = {1'b0, a_val} + {1'b0, b_opnd} + {{DATA_W{1'b0}}, alu_sub};
  assign alu_res = sum[DATA_W-1:0];

  always_comb begin
    src = SRC_EXT;
    if (alu_oe)
      src = SRC_ALU;
    else if (a_oe)
      src = SRC_A;
    else if (b_oe)
      src = SRC_B;
    else if (pc_oe)
      src = SRC_PC;
  end

  always_comb begin
    bus = bus_in;
    case (src)
      SRC_ALU: bus = alu_res;
      SRC_A:   bus = a_val;
      SRC_B:   bus = b_val;
      SRC_PC:  bus = {{(DATA_W-PC_W){1'b0}}, pc_val};
      default: bus = bus_in;
    endcase
  end

  assign bus_out   = bus;
  assign bus_drive = alu_oe | a_oe | b_oe | pc_oe;

`ifdef SAP_DP_CONFLICT_DET_EN
  assign bus_conflict = (alu_oe & a_oe) | (alu_oe & b_oe) | (alu_oe & pc_oe) |
                        (a_oe & b_oe) | (a_oe & pc_oe) | (b_oe & pc_oe);
`else
  assign bus_conflict = 1'b0;
`endif

  dp_reg #(.W(DATA_W)) u_reg_a (
    .clk (clk),
    .clr (clr),
    .we  (a_we),
    .d   (bus),
    .q   (a_val)
  );

  dp_reg #(.W(DATA_W)) u_reg_b (
    .clk (clk),
    .clr (clr),
    .we  (b_we),
    .d   (bus),
    .q   (b_val)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      pc_val <= '0;
    else if (pc_jmp)
      pc_val <= bus[PC_W-1:0];
    else if (pc_inc)
      pc_val <= pc_val + PC_ONE;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cf <= 1'b0;
      zf <= 1'b0;
    end else if (flags_we) begin
      cf <= sum[DATA_W];
      zf <= (alu_res == '0);
    end
  end

endmodule

// File: tb/tb_sap_datapath.sv
// Directed scoreboard bench for sap_datapath (default 8-bit data, 4-bit PC).
module tb_sap_datapath;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_drive;
  logic       pc_oe, pc_jmp, pc_inc;
  logic       a_we, a_oe, b_we, b_oe;
  logic       alu_oe, alu_sub, flags_we;
  logic [3:0] pc_val;
  logic [7:0] a_val, b_val;
  logic       cf, zf;
  logic       bus_conflict;

`ifdef SAP_DP_CONFLICT_DET_EN
  localparam logic CONF_EXP = 1'b1;
`else
  localparam logic CONF_EXP = 1'b0;
`endif

  localparam logic [9:0] PC_OE    = 10'b10_0000_0000;
  localparam logic [9:0] PC_JMP   = 10'b01_0000_0000;
  localparam logic [9:0] PC_INC   = 10'b00_1000_0000;
  localparam logic [9:0] A_WE     = 10'b00_0100_0000;
  localparam logic [9:0] A_OE     = 10'b00_0010_0000;
  localparam logic [9:0] B_WE     = 10'b00_0001_0000;
  localparam logic [9:0] B_OE     = 10'b00_0000_1000;
  localparam logic [9:0] ALU_OE   = 10'b00_0000_0100;
  localparam logic [9:0] ALU_SUB  = 10'b00_0000_0010;
  localparam logic [9:0] FLAGS_WE = 10'b00_0000_0001;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sap_datapath dut (
    .clk          (clk),
    .clr          (clr),
    .bus_in       (bus_in),
    .bus_out      (bus_out),
    .bus_drive    (bus_drive),
    .pc_oe        (pc_oe),
    .pc_jmp       (pc_jmp),
    .pc_inc       (pc_inc),
    .a_we         (a_we),
    .a_oe         (a_oe),
    .b_we         (b_we),
    .b_oe         (b_oe),
    .alu_oe       (alu_oe),
    .alu_sub      (alu_sub),
    .flags_we     (flags_we),
    .pc_val       (pc_val),
    .a_val        (a_val),
    .b_val        (b_val),
    .cf           (cf),
    .zf           (zf),
    .bus_conflict (bus_conflict)
  );

  task automatic applyStimulus(input logic [9:0] ctrl, input logic [7:0] din);
    {pc_oe, pc_jmp, pc_inc, a_we, a_oe, b_we, b_oe, alu_oe, alu_sub, flags_we} = ctrl;
    bus_in = din;
  endtask

  task automatic pushExp(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [15:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty: observed %0h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRegsZero(input string pfx);
    pushExp({pfx, "_pc"}, 16'h0); checkOutput(16'(pc_val));
    pushExp({pfx, "_a"},  16'h0); checkOutput(16'(a_val));
    pushExp({pfx, "_b"},  16'h0); checkOutput(16'(b_val));
    pushExp({pfx, "_cf"}, 16'h0); checkOutput(16'(cf));
    pushExp({pfx, "_zf"}, 16'h0); checkOutput(16'(zf));
  endtask

  initial begin
    clr = 1'b1;
    applyStimulus(10'b0, 8'h00);
    #2;
    checkRegsZero("reset");
    @(posedge clk);
    #1 clr = 1'b0;

    // Add 0x38 + 0x23 and write the result back into A
    applyStimulus(A_WE, 8'h38); step();
    pushExp("load_a38", 16'h38); checkOutput(16'(a_val));
    applyStimulus(B_WE, 8'h23); step();
    pushExp("load_b23", 16'h23); checkOutput(16'(b_val));
    applyStimulus(ALU_OE | A_WE | FLAGS_WE, 8'h00);
    pushExp("add_bus", 16'h5B); pushExp("add_drive", 16'h1); pushExp("add_conf", 16'h0);
    #1;
    checkOutput(16'(bus_out)); checkOutput(16'(bus_drive)); checkOutput(16'(bus_conflict));
    step();
    pushExp("add_a", 16'h5B); pushExp("add_cf", 16'h0); pushExp("add_zf", 16'h0);
    checkOutput(16'(a_val)); checkOutput(16'(cf)); checkOutput(16'(zf));

    // Subtraction cases: no borrow, borrow, equal operands
    applyStimulus(A_WE, 8'h38); step();
    applyStimulus(ALU_SUB | ALU_OE | FLAGS_WE, 8'h00);
    pushExp("sub1_bus", 16'h15); #1 checkOutput(16'(bus_out));
    step();
    pushExp("sub1_cf", 16'h1); pushExp("sub1_zf", 16'h0);
    checkOutput(16'(cf)); checkOutput(16'(zf));

    applyStimulus(A_WE, 8'h23); step();
    applyStimulus(B_WE, 8'h38); step();
    applyStimulus(ALU_SUB | ALU_OE | FLAGS_WE, 8'h00);
    pushExp("sub2_bus", 16'hEB); #1 checkOutput(16'(bus_out));
    step();
    pushExp("sub2_cf", 16'h0); pushExp("sub2_zf", 16'h0);
    checkOutput(16'(cf)); checkOutput(16'(zf));

    applyStimulus(B_WE, 8'h23); step();
    applyStimulus(ALU_SUB | ALU_OE | FLAGS_WE, 8'h00);
    pushExp("sub3_bus", 16'h00); #1 checkOutput(16'(bus_out));
    step();
    pushExp("sub3_cf", 16'h1); pushExp("sub3_zf", 16'h1);
    checkOutput(16'(cf)); checkOutput(16'(zf));

    // Add overflow, then flag hold with flags_we low
    applyStimulus(A_WE, 8'hFF); step();
    applyStimulus(B_WE, 8'h01); step();
    applyStimulus(ALU_OE | FLAGS_WE, 8'h00);
    pushExp("ovf_bus", 16'h00); #1 checkOutput(16'(bus_out));
    step();
    pushExp("ovf_cf", 16'h1); pushExp("ovf_zf", 16'h1);
    checkOutput(16'(cf)); checkOutput(16'(zf));

    applyStimulus(A_WE, 8'h01); step();
    applyStimulus(ALU_OE | FLAGS_WE, 8'h00);
    pushExp("add2_bus", 16'h02); #1 checkOutput(16'(bus_out));
    step();
    pushExp("add2_cf", 16'h0); pushExp("add2_zf", 16'h0);
    checkOutput(16'(cf)); checkOutput(16'(zf));

    applyStimulus(A_WE, 8'hFF); step();
    applyStimulus(ALU_OE, 8'h00);
    pushExp("nowe_bus", 16'h00); #1 checkOutput(16'(bus_out));
    step();
    pushExp("nowe_cf", 16'h0); pushExp("nowe_zf", 16'h0);
    checkOutput(16'(cf)); checkOutput(16'(zf));

    // Flags latch even when the ALU is not driving the bus
    applyStimulus(FLAGS_WE, 8'h00); step();
    pushExp("flagonly_cf", 16'h1); pushExp("flagonly_zf", 16'h1);
    checkOutput(16'(cf)); checkOutput(16'(zf));

    // A sourcing its own write holds its value
    applyStimulus(A_OE | A_WE, 8'h77);
    pushExp("self_bus", 16'hFF); #1 checkOutput(16'(bus_out));
    step();
    pushExp("self_a", 16'hFF); checkOutput(16'(a_val));

    // Counter wrap, jump priority, PC onto bus
    for (int i = 0; i < 16; i++) begin
      applyStimulus(PC_INC, 8'h00); step();
      if (i == 14) begin
        pushExp("pc_15", 16'hF); checkOutput(16'(pc_val));
      end
    end
    pushExp("pc_wrap", 16'h0); checkOutput(16'(pc_val));
    applyStimulus(PC_JMP | PC_INC, 8'h0E); step();
    pushExp("pc_jmp", 16'hE); checkOutput(16'(pc_val));
    applyStimulus(PC_OE, 8'h5A);
    pushExp("pcoe_bus", 16'h0E); pushExp("pcoe_drive", 16'h1); pushExp("pcoe_conf", 16'h0);
    #1;
    checkOutput(16'(bus_out)); checkOutput(16'(bus_drive)); checkOutput(16'(bus_conflict));

    // Priority among simultaneous enables
    applyStimulus(A_OE | PC_OE, 8'h5A);
    pushExp("apc_bus", 16'hFF); pushExp("apc_conf", 16'(CONF_EXP));
    #1 checkOutput(16'(bus_out)); checkOutput(16'(bus_conflict));
    applyStimulus(B_OE | PC_OE, 8'h5A);
    pushExp("bpc_bus", 16'h01); pushExp("bpc_conf", 16'(CONF_EXP));
    #1 checkOutput(16'(bus_out)); checkOutput(16'(bus_conflict));
    applyStimulus(ALU_OE | B_OE, 8'h5A);
    pushExp("alub_bus", 16'h00); pushExp("alub_conf", 16'(CONF_EXP));
    #1 checkOutput(16'(bus_out)); checkOutput(16'(bus_conflict));
    applyStimulus(B_OE, 8'h5A);
    pushExp("bonly_bus", 16'h01); pushExp("bonly_conf", 16'h0);
    #1 checkOutput(16'(bus_out)); checkOutput(16'(bus_conflict));
    applyStimulus(10'b0, 8'h5A);
    pushExp("idle_bus", 16'h5A); pushExp("idle_drive", 16'h0); pushExp("idle_conf", 16'h0);
    #1 checkOutput(16'(bus_out)); checkOutput(16'(bus_drive)); checkOutput(16'(bus_conflict));

    // Mid-cycle clear overrides pending writes and increments
    applyStimulus(A_WE, 8'h55); step();
    applyStimulus(PC_JMP, 8'h07); step();
    pushExp("pre_clr_a", 16'h55); checkOutput(16'(a_val));
    pushExp("pre_clr_pc", 16'h7); checkOutput(16'(pc_val));
    applyStimulus(A_WE | B_WE | PC_INC | FLAGS_WE, 8'hAA);
    #3 clr = 1'b1;
    #1;
    checkRegsZero("clr_mid");
    applyStimulus(PC_OE | A_WE | PC_INC, 8'hAA);
    pushExp("clr_bus", 16'h00); pushExp("clr_drive", 16'h1);
    #1 checkOutput(16'(bus_out)); checkOutput(16'(bus_drive));
    step();
    pushExp("clr_hold_a", 16'h00); checkOutput(16'(a_val));
    pushExp("clr_hold_pc", 16'h0); checkOutput(16'(pc_val));
    clr = 1'b0;
    applyStimulus(10'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
